// File: rtl/cluster_rst_seq_pkg.sv
// Shared types and default timing for the cluster reset sequencer.
package cluster_rst_seq_pkg;

  typedef enum logic [2:0] {
    CKEN_RAMP = 3'd0,
    SYNC_WAIT = 3'd1,
    RUN       = 3'd2,
    DBG_PULSE = 3'd3,
    WRST_HOLD = 3'd4
  } seq_state_e;

  localparam int DEF_STAGGER_CYC = 2;
  localparam int DEF_SYNC_CYC    = 4;
  localparam int DEF_DBG_CYC     = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cluster_rst_seq_if.sv
// Request/header bundle of the cluster reset sequencer; cken_mask exists only
// when CLUSTER_RST_SEQ_CKEN_OVRD_EN is defined.
interface cluster_rst_seq_if #(
  parameter int NUM_CLUSTERS = 4
);
  logic                    wrst_req;
  logic                    dbg_req;
  logic [NUM_CLUSTERS-1:0] cluster_cken;
  logic                    grst_l;
  logic                    gdbginit_l;
  logic                    seq_busy;
  logic                    seq_done;
`ifdef CLUSTER_RST_SEQ_CKEN_OVRD_EN
  logic [NUM_CLUSTERS-1:0] cken_mask;

  modport master (output wrst_req, dbg_req, cken_mask,
                  input  cluster_cken, grst_l, gdbginit_l, seq_busy, seq_done);
  modport slave  (input  wrst_req, dbg_req, cken_mask,
                  output cluster_cken, grst_l, gdbginit_l, seq_busy, seq_done);
`else
  modport master (output wrst_req, dbg_req,
                  input  cluster_cken, grst_l, gdbginit_l, seq_busy, seq_done);
  modport slave  (input  wrst_req, dbg_req,
                  output cluster_cken, grst_l, gdbginit_l, seq_busy, seq_done);
`endif
endinterface

// File: rtl/cluster_seq_timer.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module cluster_seq_timer #(
  parameter int W = 4
) (
  input  logic         gclk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Count register: load wins, otherwise decrement until zero.
  always_ff @(posedge gclk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cluster_rst_seq.sv
// Cluster reset sequencer: staggered clock-enable ramp, settle, global reset
// release, debug-init pulses and warm reset. Optional CLUSTER_RST_SEQ_CKEN_OVRD_EN.
module cluster_rst_seq
  import cluster_rst_seq_pkg::*;
#(
  parameter int NUM_CLUSTERS = 4,
  parameter int STAGGER_CYC  = DEF_STAGGER_CYC,
  parameter int SYNC_CYC     = DEF_SYNC_CYC,
  parameter int DBG_CYC      = DEF_DBG_CYC
) (
  input  logic               gclk,
  input  logic               reset,
  cluster_rst_seq_if.slave   bus
);

  localparam int TMR_W = $clog2(max3(STAGGER_CYC, SYNC_CYC, DBG_CYC)) + 1;

  if (NUM_CLUSTERS < 1 || STAGGER_CYC < 1 || SYNC_CYC < 1 || DBG_CYC < 1) begin : g_param_chk
    $error("cluster_rst_seq: all parameters must be at least 1");
  end

  seq_state_e              state_q, state_d;
  logic [NUM_CLUSTERS-1:0] cken_q, cken_d, ramp_s;
  logic                    grst_q, grst_d;
  logic                    dbg_q, dbg_d;
  logic                    busy_q, done_q;
  logic                    tmr_load_s, tmr_zero_s;
  logic [TMR_W-1:0]        tmr_val_s;

  cluster_seq_timer #(.W(TMR_W)) u_timer (
    .gclk       (gclk),
    .reset      (reset),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .zero_o     (tmr_zero_s)
  );

  // Ramp fills enables from bit 0 upward, one more cluster per step.
  assign ramp_s = (cken_q << 1) | NUM_CLUSTERS'(1);

  // Next-state and next-output logic; the timer is reloaded on every state entry.
  always_comb begin
    state_d    = state_q;
    cken_d     = cken_q;
    grst_d     = grst_q;
    dbg_d      = dbg_q;
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;
    case (state_q)
      CKEN_RAMP: begin
        if (tmr_zero_s) begin
          cken_d     = ramp_s;
          tmr_load_s = 1'b1;
          if (ramp_s[NUM_CLUSTERS-1]) begin
            state_d   = SYNC_WAIT;
            tmr_val_s = TMR_W'(SYNC_CYC - 1);
          end else begin
            tmr_val_s = TMR_W'(STAGGER_CYC - 1);
          end
        end else begin
          state_d = CKEN_RAMP;
        end
      end
      SYNC_WAIT: begin
        if (tmr_zero_s) begin
          state_d = RUN;
          grst_d  = 1'b1;
          dbg_d   = 1'b1;
        end else begin
          state_d = SYNC_WAIT;
        end
      end
      RUN: begin
        if (bus.wrst_req) begin
          state_d    = WRST_HOLD;
          grst_d     = 1'b0;
          dbg_d      = 1'b0;
          tmr_load_s = 1'b1;
          tmr_val_s  = TMR_W'(SYNC_CYC - 1);
        end else if (bus.dbg_req) begin
          state_d    = DBG_PULSE;
          dbg_d      = 1'b0;
          tmr_load_s = 1'b1;
          tmr_val_s  = TMR_W'(DBG_CYC - 1);
        end else begin
          state_d = RUN;
        end
      end
      DBG_PULSE: begin
        if (bus.wrst_req) begin
          state_d    = WRST_HOLD;
          grst_d     = 1'b0;
          dbg_d      = 1'b0;
          tmr_load_s = 1'b1;
          tmr_val_s  = TMR_W'(SYNC_CYC - 1);
        end else if (tmr_zero_s) begin
          state_d = RUN;
          dbg_d   = 1'b1;
        end else begin
          state_d = DBG_PULSE;
        end
      end
      WRST_HOLD: begin
        // Clocks drop for the first ramp cycle so headers see a clean restart.
        if (tmr_zero_s) begin
          state_d    = CKEN_RAMP;
          cken_d     = '0;
          tmr_load_s = 1'b1;
          tmr_val_s  = '0;
        end else begin
          state_d = WRST_HOLD;
        end
      end
      default: begin
        state_d    = CKEN_RAMP;
        cken_d     = '0;
        grst_d     = 1'b0;
        dbg_d      = 1'b0;
        tmr_load_s = 1'b1;
        tmr_val_s  = '0;
      end
    endcase
  end

  // State and registered output flops.
  always_ff @(posedge gclk) begin
    if (reset) begin
      state_q <= CKEN_RAMP;
      cken_q  <= '0;
      grst_q  <= 1'b0;
      dbg_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cken_q  <= cken_d;
      grst_q  <= grst_d;
      dbg_q   <= dbg_d;
      busy_q  <= (state_d != RUN);
      done_q  <= (state_d == RUN);
    end
  end

`ifdef CLUSTER_RST_SEQ_CKEN_OVRD_EN
  logic [NUM_CLUSTERS-1:0] cken_out_q;

  // Masked copy of the enables, same latency as the unmasked path.
  always_ff @(posedge gclk) begin
    if (reset) begin
      cken_out_q <= '0;
    end else begin
      cken_out_q <= cken_d & ~bus.cken_mask;
    end
  end

  assign bus.cluster_cken = cken_out_q;
`else
  assign bus.cluster_cken = cken_q;
`endif

  assign bus.grst_l     = grst_q;
  assign bus.gdbginit_l = dbg_q;
  assign bus.seq_busy   = busy_q;
  assign bus.seq_done   = done_q;

endmodule

// File: tb/tb_cluster_rst_seq.sv
// Directed bench for cluster_rst_seq with default parameters.
module tb_cluster_rst_seq;

  logic       gclk;
  logic       reset;
  logic [3:0] mask_v;
  int         n_cmp;
  int         n_err;

  logic [3:0] ramp_tbl [0:11] = '{4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h7,
                                  4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};

  cluster_rst_seq_if #(.NUM_CLUSTERS(4)) bus ();

  cluster_rst_seq #(.NUM_CLUSTERS(4)) dut (
    .gclk  (gclk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef CLUSTER_RST_SEQ_CKEN_OVRD_EN
  assign bus.cken_mask = mask_v;
`endif

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] cken, input logic grst,
                     input logic dbg, input logic busy, input logic done);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {bus.cluster_cken, bus.grst_l, bus.gdbginit_l, bus.seq_busy, bus.seq_done};
    exp = {cken & ~mask_v, grst, dbg, busy, done};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed cken/grst/dbg/busy/done=%b expected %b", tag, obs, exp);
    end
  endtask

  // Checks ramp cycles 0..11 starting in cycle 0; optionally pokes ignored requests.
  task automatic ramp_check(input string tag, input bit inject);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      if (inject) begin
        bus.dbg_req  = (k == 4);
        bus.wrst_req = (k == 8);
      end
      chk(tag, ramp_tbl[k], k == 11, k == 11, k != 11, k == 11);
    end
    bus.dbg_req  = 1'b0;
    bus.wrst_req = 1'b0;
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    mask_v       = 4'h0;
    reset        = 1'b1;
    bus.wrst_req = 1'b0;
    bus.dbg_req  = 1'b0;

    // Reset values
    step(); step(); step();
    chk("reset", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Cold ramp with requests that must be ignored in CKEN_RAMP / SYNC_WAIT
    reset = 1'b0;
    ramp_check("cold_ramp", 1'b1);

    // Stays in RUN until cycle 20
    repeat (9) step();
    chk("run_c20", 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);

    // Debug-init pulse: low for cycles 21..28, repeat request at 23 ignored
    bus.dbg_req = 1'b1;
    for (int k = 21; k <= 28; k++) begin
      step();
      bus.dbg_req = (k == 23);
      chk("dbg_pulse", 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    bus.dbg_req = 1'b0;
    step();
    chk("dbg_end_c29", 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);

    // Simultaneous warm reset and debug request in RUN: warm reset wins
    step();
    bus.wrst_req = 1'b1;
    bus.dbg_req  = 1'b1;
    step();
    bus.wrst_req = 1'b0;
    bus.dbg_req  = 1'b0;
    chk("wrst_hold", 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) begin
      step();
      chk("wrst_hold", 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    step();
    ramp_check("wrst_ramp", 1'b0);
    step();
    chk("wrst_run", 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);

    // Warm reset taking over a debug pulse
    bus.dbg_req = 1'b1;
    step();
    bus.dbg_req = 1'b0;
    chk("dbg2_pulse", 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    bus.wrst_req = 1'b1;
    step();
    bus.wrst_req = 1'b0;
    chk("dbg_wrst_hold", 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) begin
      step();
      chk("dbg_wrst_hold", 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    step();
    ramp_check("dbg_wrst_ramp", 1'b0);

    // Reset pulse during a debug pulse aborts on the next edge
    step();
    bus.dbg_req = 1'b1;
    step();
    bus.dbg_req = 1'b0;
    chk("dbg3_pulse", 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef CLUSTER_RST_SEQ_CKEN_OVRD_EN
    mask_v = 4'b0100;
`endif
    reset = 1'b1;
    step();
    chk("abort_reset", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("abort_reset_hold", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    ramp_check("post_abort_ramp", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cluster_rst_seq.md
CLUSTER_RST_SEQ -- requirements
Module: cluster_rst_seq

Interface
REQ-001 The module SHALL have parameter NUM_CLUSTERS, default 4, giving the number of cluster headers driven.
REQ-002 The module SHALL have parameter STAGGER_CYC, default 2, giving the cycles between successive cluster enables.
REQ-003 The module SHALL have parameter SYNC_CYC, default 4, giving the settle cycles that cover header synchronizer latency.
REQ-004 The module SHALL have parameter DBG_CYC, default 8, giving the low width of a debug-init pulse.
REQ-005 The module SHALL have port gclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have port wrst_req, input, 1 bit: one-cycle warm-reset request.
REQ-008 The module SHALL have port dbg_req, input, 1 bit: one-cycle debug-init request.
REQ-009 The module SHALL have port cluster_cken, output, NUM_CLUSTERS bits: per-cluster clock enables to the cluster headers.
REQ-010 The module SHALL have port grst_l, output, 1 bit: global reset to the cluster headers, active-low.
REQ-011 The module SHALL have port gdbginit_l, output, 1 bit: global debug init to the cluster headers, active-low.
REQ-012 The module SHALL have port seq_busy, output, 1 bit: high whenever the state is not RUN.
REQ-013 The module SHALL have port seq_done, output, 1 bit: high only in RUN.

Function
REQ-014 The FSM SHALL have states CKEN_RAMP, SYNC_WAIT, RUN, DBG_PULSE and WRST_HOLD, all registered outputs.
REQ-015 In CKEN_RAMP the FSM SHALL set cluster_cken[i] at cycle 1+i*STAGGER_CYC after entry (cycle 0 = entry), ascending i.
REQ-016 Once cluster_cken[NUM_CLUSTERS-1] is set, the FSM SHALL hold SYNC_WAIT for SYNC_CYC cycles, then enter RUN.
REQ-017 On RUN entry, grst_l and gdbginit_l SHALL both rise in the same cycle; seq_done=1 and seq_busy=0.
REQ-018 A dbg_req sampled in RUN SHALL drive gdbginit_l=0 the next cycle for exactly DBG_CYC cycles, then return to RUN; grst_l and cluster_cken stay unchanged.
REQ-019 A wrst_req sampled in RUN or DBG_PULSE SHALL drive grst_l=0 and gdbginit_l=0 the next cycle and enter WRST_HOLD.
REQ-020 WRST_HOLD SHALL last SYNC_CYC cycles with clocks enabled; cluster_cken SHALL then clear to all-zero for one cycle before CKEN_RAMP re-entry.
REQ-021 When wrst_req and dbg_req are sampled together, wrst_req SHALL win and dbg_req SHALL be dropped.
REQ-022 Requests in CKEN_RAMP, SYNC_WAIT or WRST_HOLD, and dbg_req in DBG_PULSE, SHALL be ignored and not queued.
REQ-023 The cycle counter SHALL be $clog2 of the largest interval plus 1 bits wide, reload on each state entry, and never wrap.
REQ-024 Parameters below 1 SHALL be rejected by an elaboration-time check.

Reset
REQ-025 While reset=1 the outputs SHALL be cluster_cken=0, grst_l=0, gdbginit_l=0, seq_busy=1, seq_done=0, with the state held at CKEN_RAMP entry.
REQ-026 Reset asserted mid-sequence SHALL abort any state on the next edge without glitching the outputs.
REQ-027 The first cycle with reset=0 SHALL be cycle 0 of CKEN_RAMP.

Configuration
REQ-028 With CLUSTER_RST_SEQ_CKEN_OVRD_EN defined, input cken_mask[NUM_CLUSTERS-1:0] SHALL exist and cluster_cken SHALL equal the internal enable AND NOT cken_mask, registered.
REQ-029 The mask SHALL NOT alter FSM timing.
REQ-030 Without CLUSTER_RST_SEQ_CKEN_OVRD_EN, the port SHALL be absent and cluster_cken SHALL equal the internal enable.

Structure
REQ-031 Shared package cluster_rst_seq_pkg SHALL hold the state enum and the default values of STAGGER_CYC, SYNC_CYC and DBG_CYC.
REQ-032 Sub-module cluster_seq_timer, a loadable down-counter with a zero flag, SHALL provide all interval timing.

Verification
REQ-033 Release reset with defaults -> cluster_cken bits rise at cycles 1,3,5,7; grst_l, gdbginit_l and seq_done rise at cycle 11.
REQ-034 dbg_req at RUN cycle 20 -> gdbginit_l low for cycles 21-28, high at 29; grst_l stays 1 and cluster_cken stays 4'hF.
REQ-035 wrst_req in RUN -> grst_l low next cycle; cluster_cken stays 4'hF for 4 cycles, goes 4'h0 for 1 cycle, then ramps again; grst_l high 11 cycles after re-entry.
REQ-036 wrst_req and dbg_req in the same RUN cycle -> warm-reset sequence only, with no standalone dbginit pulse.
REQ-037 dbg_req during CKEN_RAMP, and a reset pulse during DBG_PULSE -> request ignored; reset values on the next edge, then a clean ramp.
REQ-038 With CLUSTER_RST_SEQ_CKEN_OVRD_EN and cken_mask=4'b0100 -> cluster_cken reaches 4'b1011 and grst_l still rises at cycle 11.
